// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU inputs.
// Holds one decoded instruction, refreshes stored operands from WB while stalled.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [IDX_W-1:0]  id_src_a,
    input  logic [IDX_W-1:0]  id_src_b,
    input  logic [IDX_W-1:0]  id_rd,
    input  logic              id_wr_en,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_wr_en,
    input  logic [IDX_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wr_en,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_alu_ctrl,
    output logic [IDX_W-1:0]  ex_rd,
    output logic              ex_wr_en
);

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [3:0]        alu_ctrl;
        logic [IDX_W-1:0]  rd;
        logic [IDX_W-1:0]  src_a;
        logic [IDX_W-1:0]  src_b;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } stage_t;

    // Code 1111 is pass-B in the ALU, so a bubble has no side effects.
    localparam logic [3:0] ALU_PASS_B = 4'b1111;
    localparam stage_t BUBBLE = '{
        valid: 1'b0, wr_en: 1'b0, alu_ctrl: ALU_PASS_B,
        rd: '0, src_a: '0, src_b: '0, a: '0, b: '0
    };

    stage_t stage_q, stage_d;
    logic   mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // Register 0 is hard-wired to zero, so it never matches a producer.
    always_comb begin
        mem_hit_a = mem_wr_en && (stage_q.src_a != '0) && (mem_rd == stage_q.src_a);
        mem_hit_b = mem_wr_en && (stage_q.src_b != '0) && (mem_rd == stage_q.src_b);
        wb_hit_a  = wb_wr_en  && (stage_q.src_a != '0) && (wb_rd  == stage_q.src_a);
        wb_hit_b  = wb_wr_en  && (stage_q.src_b != '0) && (wb_rd  == stage_q.src_b);
    end

    always_comb begin
        // NOTE: default every field first so no path through the block infers a latch.
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (!stall) begin
            if (id_valid) begin
                stage_d = '{
                    valid: 1'b1, wr_en: id_wr_en, alu_ctrl: id_alu_ctrl,
                    rd: id_rd, src_a: id_src_a, src_b: id_src_b, a: id_a, b: id_b
                };
            end else begin
                stage_d = BUBBLE;
            end
        end else begin
            // WB retires during the stall; capture its value before it disappears.
            if (wb_hit_a && !mem_hit_a) stage_d.a = wb_result;
            if (wb_hit_b && !mem_hit_b) stage_d.b = wb_result;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= BUBBLE;
        else     stage_q <= stage_d;
    end

    always_comb begin
        ex_valid    = stage_q.valid;
        ex_wr_en    = stage_q.valid && stage_q.wr_en;
        ex_alu_ctrl = stage_q.alu_ctrl;
        ex_rd       = stage_q.rd;
        ex_a        = stage_q.a;
        ex_b        = stage_q.b;
        if (stage_q.valid) begin
            if (mem_hit_a)     ex_a = mem_result;
            else if (wb_hit_a) ex_a = wb_result;
            if (mem_hit_b)     ex_b = mem_result;
            else if (wb_hit_b) ex_b = wb_result;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared with a newest-producer-wins reference model.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;
    localparam int OUT_W  = 1 + 1 + 4 + IDX_W + 2 * DATA_W;
    localparam logic [OUT_W-1:0] RESET_OUT = {1'b0, 1'b0, 4'hF, {IDX_W{1'b0}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}};

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [3:0]        id_alu_ctrl;
    logic [DATA_W-1:0] id_a, id_b;
    logic [IDX_W-1:0]  id_src_a, id_src_b, id_rd;
    logic              id_wr_en;
    logic              stall, flush;
    logic              mem_wr_en;
    logic [IDX_W-1:0]  mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_wr_en;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_result;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [3:0]        ex_alu_ctrl;
    logic [IDX_W-1:0]  ex_rd;
    logic              ex_wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl), .id_a(id_a), .id_b(id_b),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .stall(stall), .flush(flush),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en)
    );

    always #5 clk = ~clk;

    logic [OUT_W-1:0] dut_out;
    assign dut_out = {ex_valid, ex_wr_en, ex_alu_ctrl, ex_rd, ex_a, ex_b};

    // Reference model: the instruction currently held in EX.
    logic              m_valid, m_wr;
    logic [3:0]        m_ctrl;
    logic [IDX_W-1:0]  m_rd, m_sa, m_sb;
    logic [DATA_W-1:0] m_a, m_b;

    task automatic model_bubble();
        m_valid = 0; m_wr = 0; m_ctrl = 4'hF; m_rd = 0; m_sa = 0; m_sb = 0; m_a = 0; m_b = 0;
    endtask

    // Value of register r as EX should see it: the youngest in-flight writer wins.
    function automatic logic [DATA_W-1:0] reg_view(input logic [IDX_W-1:0] r, input logic [DATA_W-1:0] stored);
        if (r == 0)                        return stored;
        if (mem_wr_en && mem_rd == r)      return mem_result;
        if (wb_wr_en && wb_rd == r)        return wb_result;
        return stored;
    endfunction

    function automatic logic [OUT_W-1:0] exp_out();
        logic [DATA_W-1:0] a, b;
        a = m_valid ? reg_view(m_sa, m_a) : m_a;
        b = m_valid ? reg_view(m_sb, m_b) : m_b;
        return {m_valid, m_valid & m_wr, m_ctrl, m_rd, a, b};
    endfunction

    task automatic model_edge();
        if (flush || (!stall && !id_valid)) begin
            model_bubble();
        end else if (!stall) begin
            m_valid = 1; m_wr = id_wr_en; m_ctrl = id_alu_ctrl; m_rd = id_rd;
            m_sa = id_src_a; m_sb = id_src_b; m_a = id_a; m_b = id_b;
        end else begin
            // The stored copy must end up holding what WB delivered, unless MEM is younger.
            if (m_sa != 0 && wb_wr_en && wb_rd == m_sa && !(mem_wr_en && mem_rd == m_sa)) m_a = wb_result;
            if (m_sb != 0 && wb_wr_en && wb_rd == m_sb && !(mem_wr_en && mem_rd == m_sb)) m_b = wb_result;
        end
    endtask

    // Advance one clock: update the model at the edge, return at the following negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_bubble(); else model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_alu_ctrl = 0; id_a = 0; id_b = 0; id_src_a = 0; id_src_b = 0;
        id_rd = 0; id_wr_en = 0; stall = 0; flush = 0;
        mem_wr_en = 0; mem_rd = 0; mem_result = 0; wb_wr_en = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic load_instr(input logic [3:0] ctrl, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [IDX_W-1:0] sa, input logic [IDX_W-1:0] sb, input logic [IDX_W-1:0] rd);
        id_valid = 1; id_alu_ctrl = ctrl; id_a = a; id_b = b;
        id_src_a = sa; id_src_b = sb; id_rd = rd; id_wr_en = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        load_instr(4'h3, 32'h55, 32'h66, 4'd1, 4'd2, 4'd3);
        #2;
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", dut_out, RESET_OUT);
        end
        tick();
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_fail++; $display("FAIL reset_holds_over_edge: got %h expected %h", dut_out, RESET_OUT);
        end
        rst = 0;
        model_bubble();
        idle_inputs();
        tick();
    endtask

    task automatic test_pass_through();
        load_instr(4'b1110, 32'd5, 32'd7, 4'd2, 4'd3, 4'd9);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (ex_a !== 32'd5 || ex_b !== 32'd7 || ex_alu_ctrl !== 4'b1110 || ex_valid !== 1'b1 || ex_wr_en !== 1'b1 || ex_rd !== 4'd9) begin
            n_fail++; $display("FAIL pass_through: got a=%h b=%h ctrl=%h v=%b we=%b rd=%h expected 5 7 e 1 1 9",
                               ex_a, ex_b, ex_alu_ctrl, ex_valid, ex_wr_en, ex_rd);
        end
    endtask

    task automatic test_priority();
        load_instr(4'h0, 32'h11, 32'h22, 4'd4, 4'd5, 4'd6);
        tick();
        idle_inputs();
        mem_wr_en = 1; mem_rd = 4'd4; mem_result = 32'hAA;
        wb_wr_en = 1;  wb_rd = 4'd4;  wb_result = 32'hBB;
        #1;
        n_checks++;
        if (ex_a !== 32'hAA || ex_b !== 32'h22) begin
            n_fail++; $display("FAIL priority_mem: got a=%h b=%h expected aa 22", ex_a, ex_b);
        end
        mem_wr_en = 0;
        #1;
        n_checks++;
        if (ex_a !== 32'hBB) begin
            n_fail++; $display("FAIL priority_wb: got a=%h expected bb", ex_a);
        end
    endtask

    task automatic test_reg0();
        load_instr(4'h1, 32'h0, 32'h0, 4'd0, 4'd0, 4'd2);
        tick();
        idle_inputs();
        mem_wr_en = 1; mem_rd = 4'd0; mem_result = 32'hFF;
        wb_wr_en = 1;  wb_rd = 4'd0;  wb_result = 32'hEE;
        #1;
        n_checks++;
        if (ex_b !== 32'h0 || ex_a !== 32'h0) begin
            n_fail++; $display("FAIL reg0_no_forward: got a=%h b=%h expected 0 0", ex_a, ex_b);
        end
    endtask

    task automatic test_bubble_no_forward();
        idle_inputs();
        tick();
        mem_wr_en = 1; mem_rd = 4'd0; mem_result = 32'h99;
        #1;
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_fail++; $display("FAIL bubble_outputs: got %h expected %h", dut_out, RESET_OUT);
        end
    endtask

    task automatic test_stall_refresh();
        load_instr(4'h2, 32'h1, 32'h3, 4'd6, 4'd7, 4'd8);
        tick();
        idle_inputs();
        stall = 1; wb_wr_en = 1; wb_rd = 4'd6; wb_result = 32'h1234;
        #1;
        n_checks++;
        if (ex_a !== 32'h1234) begin
            n_fail++; $display("FAIL stall_fwd_wb: got a=%h expected 1234", ex_a);
        end
        tick();
        wb_wr_en = 0; wb_rd = 0; wb_result = 32'hDEAD;
        #1;
        n_checks++;
        if (ex_a !== 32'h1234 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_refresh_held: got a=%h v=%b expected 1234 1", ex_a, ex_valid);
        end
        tick();
        stall = 0;
        #1;
        n_checks++;
        if (ex_a !== 32'h1234 || ex_b !== 32'h3 || ex_alu_ctrl !== 4'h2) begin
            n_fail++; $display("FAIL stall_release: got a=%h b=%h ctrl=%h expected 1234 3 2", ex_a, ex_b, ex_alu_ctrl);
        end
    endtask

    task automatic test_stall_flush();
        load_instr(4'h5, 32'h77, 32'h88, 4'd1, 4'd2, 4'd3);
        tick();
        stall = 1; flush = 1;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0 || ex_alu_ctrl !== 4'b1111 || dut_out !== RESET_OUT) begin
            n_fail++; $display("FAIL stall_flush: got %h expected %h", dut_out, RESET_OUT);
        end
    endtask

    task automatic test_async_reset();
        load_instr(4'h6, 32'hCAFE, 32'hBEEF, 4'd3, 4'd4, 4'd5);
        tick();
        stall = 1; flush = 0;
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (dut_out !== RESET_OUT) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", dut_out, RESET_OUT);
        end
        rst = 0;
        model_bubble();
        stall = 0;
        load_instr(4'h7, 32'h42, 32'h43, 4'd1, 4'd2, 4'd3);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'h42 || ex_alu_ctrl !== 4'h7) begin
            n_fail++; $display("FAIL first_capture_after_reset: got v=%b a=%h ctrl=%h expected 1 42 7", ex_valid, ex_a, ex_alu_ctrl);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            id_alu_ctrl = 4'($urandom);
            id_a        = $urandom;
            id_b        = $urandom;
            id_src_a    = IDX_W'($urandom_range(0, 3));
            id_src_b    = IDX_W'($urandom_range(0, 3));
            id_rd       = IDX_W'($urandom);
            id_wr_en    = 1'($urandom);
            stall       = ($urandom_range(0, 9) < 3);
            flush       = ($urandom_range(0, 9) < 1);
            mem_wr_en   = 1'($urandom);
            mem_rd      = IDX_W'($urandom_range(0, 3));
            mem_result  = $urandom;
            wb_wr_en    = 1'($urandom);
            wb_rd       = IDX_W'($urandom_range(0, 3));
            wb_result   = $urandom;
            #1;
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_out, exp_out());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_bubble();
        test_reset();
        test_pass_through();
        test_priority();
        test_reg0();
        test_bubble_no_forward();
        test_stall_refresh();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
